// File: rtl/proj3_pkg.sv
// Shared types and constants for the ADC capture front end.
// Holds the frame geometry, FSM states and offset-binary to fixed-point conversion.
package proj3_pkg;

   localparam int SAMPLE_W   = 25;
   localparam int ADC_BITS   = 12;
   localparam int FRAME_BITS = 16;
   localparam int LEAD_BITS  = 4;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      SHIFT,
      HOLD
   } state_t;

   // Offset binary -> two's complement by flipping the MSB, then scale
   // so the 12-bit code lands on Q(24-frac_bits).frac_bits.
   function automatic logic signed [SAMPLE_W-1:0] code_to_fix(
      input logic [ADC_BITS-1:0] code,
      input int                  frac_bits
   );
      logic signed [ADC_BITS-1:0] s;
      logic signed [SAMPLE_W-1:0] w;
      s = signed'({~code[ADC_BITS-1], code[ADC_BITS-2:0]});
      w = SAMPLE_W'(s);
      return w <<< (frac_bits - (ADC_BITS - 1));
   endfunction

endpackage

// File: rtl/tick_div.sv
// Down-counter that emits a one-cycle tick every DIV cycles while enabled.
// Ports: clk, rst (async high), en (run; cleared when low), tick (output).
module tick_div #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

   logic [W-1:0] cnt;

   // First tick arrives DIV cycles after en rises.
   assign tick = en && (cnt == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= W'(DIV - 1);
      end else if (!en) begin
         cnt <= W'(DIV - 1);
      end else if (cnt == '0) begin
         cnt <= W'(DIV - 1);
      end else begin
         cnt <= cnt - 1'b1;
      end
   end

endmodule

// File: rtl/adc_spi_capture.sv
// Periodic SPI reader for a 12-bit AD7476-style ADC, emitting fixed-point samples.
// Ports: clk, rst, sdata in; cs_n, sclk, rx strobe, u sample, frame_err out.
module adc_spi_capture
   import proj3_pkg::*;
#(
   parameter int SCLK_DIV      = 4,
   parameter int SAMPLE_PERIOD = 200,
   parameter int FRAC_BITS     = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       sdata,
   output logic                       cs_n,
   output logic                       sclk,
   output logic                       rx,
   output logic signed [SAMPLE_W-1:0] u,
   output logic                       frame_err
);

   localparam int CNT_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;

   logic [CNT_W-1:0]      count;
   state_t                state;
   logic [FRAME_BITS-1:0] shreg;
   logic [4:0]            bits;
   logic                  tick;

   tick_div #(
      .DIV(SCLK_DIV)
   ) u_div (
      .clk (clk),
      .rst (rst),
      .en  (state != IDLE),
      .tick(tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (count == CNT_W'(SAMPLE_PERIOD - 1)) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cs_n      <= 1'b1;
         sclk      <= 1'b1;
         rx        <= 1'b0;
         u         <= '0;
         frame_err <= 1'b0;
         shreg     <= '0;
         bits      <= '0;
      end else begin
         rx        <= 1'b0;
         frame_err <= 1'b0;
         unique case (state)
            IDLE: begin
               if (count == '0) begin
                  cs_n  <= 1'b0;
                  bits  <= '0;
                  state <= SETUP;
               end
            end
            SETUP: begin
               if (tick) begin
                  sclk  <= 1'b0;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               if (tick) begin
                  // Low half ends: rise sclk and capture the bit.
                  if (!sclk) begin
                     sclk  <= 1'b1;
                     shreg <= {shreg[FRAME_BITS-2:0], sdata};
                     bits  <= bits + 1'b1;
                  end else if (bits == 5'(FRAME_BITS)) begin
                     state <= HOLD;
                  end else begin
                     sclk <= 1'b0;
                  end
               end
            end
            HOLD: begin
               if (tick) begin
                  cs_n      <= 1'b1;
                  rx        <= 1'b1;
                  u         <= code_to_fix(shreg[ADC_BITS-1:0], FRAC_BITS);
                  frame_err <= |shreg[FRAME_BITS-1:ADC_BITS];
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
